ddr_capture_wr_ctrl: RTL and testbench

- Read-side sequencer for the 8-to-256 prefetch capture FIFO in the DSO DDR path.
- Drains 256-bit words from the FIFO read port and turns them into bounded write bursts (command + data beats) to the DDR write port.
- Generates addresses inside a circular capture region and counts words per capture frame.
- Runs in the FIFO read-clock domain; the capture/trigger logic starts it and observes its status.

---
 rtl/ddr_capture_wr_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ddr_capture_wr_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_capture_wr_ctrl.sv
// Read-side sequencer for the prefetch capture FIFO: drains 256-bit words and
// packs them into bounded DDR write bursts inside a circular capture region.
//
// state  | meaning
// IDLE   | waiting for start, wr_ptr retained between frames
// CMD    | computing / presenting the next burst command
// DATA   | streaming beats of the accepted burst
// DONE   | one-cycle frame-end pulse, then back to IDLE
module ddr_capture_wr_ctrl #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 28,
  parameter int ADDR_PER_WORD = 8,
  parameter int BURST_LEN     = 16,
  parameter int LEN_WIDTH     = 20
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_region_words,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_words,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [8:0]            cmd_len,
  output logic                  wd_valid,
  input  logic                  wd_ready,
  output logic [DATA_WIDTH-1:0] wd_data,
  output logic                  wd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  wr_ptr,
  output logic [LEN_WIDTH-1:0]  words_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [LEN_WIDTH-1:0] ONE_W   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] BURST_W = LEN_WIDTH'(BURST_LEN);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  region_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [8:0]            beat;
  logic                  abort_pend;

  logic [LEN_WIDTH-1:0]  space;
  logic [LEN_WIDTH-1:0]  len_calc;
  logic [LEN_WIDTH-1:0]  len_ext;
  logic [LEN_WIDTH-1:0]  ptr_sum;
  logic [LEN_WIDTH-1:0]  ptr_next;
  logic [LEN_WIDTH-1:0]  rem_next;
  logic [ADDR_WIDTH-1:0] addr_calc;
  logic                  beat_acc;
  logic                  last_beat;
  logic                  abort_now;

  // Burst sizing: never past the frame end, the burst limit or the region end.
  always_comb begin
    space    = region_q - wr_ptr;
    len_calc = BURST_W;
    if (remaining < len_calc) len_calc = remaining;
    if (space < len_calc)     len_calc = space;
    len_ext   = LEN_WIDTH'(cmd_len);
    ptr_sum   = wr_ptr + len_ext;
    ptr_next  = (ptr_sum == region_q) ? '0 : ptr_sum;
    rem_next  = remaining - len_ext;
    addr_calc = base_q + ADDR_WIDTH'(wr_ptr) * ADDR_WIDTH'(ADDR_PER_WORD);
  end

  // The FIFO is popped only on a DDR accept, so the beat stream is the FIFO order.
  assign wd_valid   = (state == S_DATA) && fifo_rd_vld;
  assign fifo_rd_en = wd_valid && wd_ready;
  assign wd_last    = (state == S_DATA) && (beat == cmd_len - 9'd1);
  assign wd_data    = fifo_rd_data;
  assign beat_acc   = fifo_rd_en;
  assign last_beat  = beat_acc && wd_last;
  assign abort_now  = abort || abort_pend;

  // Frame sequencing, burst issue and pointer/count bookkeeping.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      region_q   <= '0;
      remaining  <= '0;
      beat       <= '0;
      abort_pend <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      wr_ptr     <= '0;
      words_done <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q     <= cfg_base;
            region_q   <= cfg_region_words;
            remaining  <= cfg_frame_words;
            words_done <= '0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            if (wr_ptr >= cfg_region_words) wr_ptr <= '0;
            busy  <= 1'b1;
            state <= S_CMD;
          end
        end
        S_CMD: begin
          // An accepted command cannot be withdrawn, so acceptance beats abort.
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            beat      <= '0;
            state     <= S_DATA;
          end else if (abort) begin
            cmd_valid <= 1'b0;
            aborted   <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= addr_calc;
            cmd_len   <= 9'(len_calc);
          end
        end
        S_DATA: begin
          if (abort) abort_pend <= 1'b1;
          if (beat_acc) begin
            words_done <= words_done + ONE_W;
            beat       <= beat + 9'd1;
          end
          if (last_beat) begin
            remaining <= rem_next;
            wr_ptr    <= ptr_next;
            beat      <= '0;
            if ((rem_next == '0) || abort_now) begin
              aborted <= abort_now;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_CMD;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_capture_wr_ctrl.sv
// Scoreboard bench: a frame-level model queues expected commands and beat
// boundaries, a monitor pops and compares on every DDR handshake.
module tb_ddr_capture_wr_ctrl;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          start, abort;
  logic [27:0]   cfg_base;
  logic [19:0]   cfg_region_words, cfg_frame_words;
  logic          fifo_rd_vld;
  logic [255:0]  fifo_rd_data;
  logic          fifo_rd_en;
  logic          cmd_valid, cmd_ready;
  logic [27:0]   cmd_addr;
  logic [8:0]    cmd_len;
  logic          wd_valid, wd_ready;
  logic [255:0]  wd_data;
  logic          wd_last, busy, done, aborted;
  logic [19:0]   wr_ptr, words_done;

  ddr_capture_wr_ctrl dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_region_words(cfg_region_words), .cfg_frame_words(cfg_frame_words),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_last(wd_last),
    .busy(busy), .done(done), .aborted(aborted), .wr_ptr(wr_ptr), .words_done(words_done)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO source: an incrementing word stream advanced by pops.
  logic [31:0] src_seq = 32'd0;
  always @(posedge rd_clk) if (fifo_rd_en) src_seq <= src_seq + 32'd1;
  assign fifo_rd_data = {8{src_seq}};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_tot++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Reference model: frame split into bursts with plain arithmetic.
  typedef struct {logic [27:0] addr; logic [8:0] len;} cmd_t;
  cmd_t cmd_q[$];
  bit   last_q[$];
  int   m_ptr = 0;

  task automatic model_frame(input logic [27:0] base, input int region, input int frame,
                             input int max_bursts, output int words);
    int rem, len, n;
    words = 0; n = 0;
    if (m_ptr >= region) m_ptr = 0;
    rem = frame;
    while (rem > 0 && n < max_bursts) begin
      len = 16;
      if (rem < len) len = rem;
      if (region - m_ptr < len) len = region - m_ptr;
      cmd_q.push_back('{base + 28'(m_ptr * 8), 9'(len)});
      for (int i = 0; i < len; i++) last_q.push_back(i == len - 1);
      m_ptr = (m_ptr + len) % region;
      rem -= len;
      words += len;
      n++;
    end
  endtask

  // Driver for handshake inputs.
  int vld_mode = 0, rdy_mode = 0, crdy_mode = 0;
  int stall_left = 0;
  bit tog = 1'b0;
  initial begin
    fifo_rd_vld = 1'b0; wd_ready = 1'b0; cmd_ready = 1'b0;
    forever begin
      @(posedge rd_clk); #1;
      tog = ~tog;
      case (vld_mode)
        0: fifo_rd_vld = 1'b1;
        1: fifo_rd_vld = tog;
        default: fifo_rd_vld = ($urandom_range(0, 3) != 0);
      endcase
      if (stall_left > 0) wd_ready = 1'b0;
      else wd_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cmd_ready = (crdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor / scoreboard.
  logic [31:0] beat_seq = 32'd0;
  int   acc_total = 0, done_cnt = 0;
  bit   in_burst = 1'b0, cmd_wait = 1'b0, exp_last;
  logic [27:0] hold_addr;
  logic [8:0]  hold_len;
  cmd_t ec;
  initial begin
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        cmd_q.delete(); last_q.delete();
        in_burst = 1'b0; cmd_wait = 1'b0; beat_seq = src_seq;
      end else begin
        if (done) done_cnt++;
        if (cmd_wait) begin
          chk("cmd_hold_valid", cmd_valid, 1'b1);
          chk("cmd_hold_addr", cmd_addr, hold_addr);
          chk("cmd_hold_len", cmd_len, hold_len);
        end
        if (in_burst || wd_valid) chk("wd_valid_mirror", wd_valid, in_burst && fifo_rd_vld);
        if (fifo_rd_en || (wd_valid && wd_ready)) chk("fifo_rd_en", fifo_rd_en, wd_valid && wd_ready);
        if (wd_valid && wd_ready) begin
          if (last_q.size() == 0) fail("beat_extra");
          else begin
            exp_last = last_q.pop_front();
            chk("wd_last", wd_last, exp_last);
            chk("wd_data", wd_data, {8{beat_seq}});
            if (exp_last) in_burst = 1'b0;
          end
          beat_seq++;
          acc_total++;
        end
        if (cmd_valid && cmd_ready) begin
          if (cmd_q.size() == 0) fail("cmd_extra");
          else begin
            ec = cmd_q.pop_front();
            chk("cmd_addr", cmd_addr, ec.addr);
            chk("cmd_len", cmd_len, ec.len);
          end
          in_burst = 1'b1;
        end
        cmd_wait  = cmd_valid && !cmd_ready;
        hold_addr = cmd_addr;
        hold_len  = cmd_len;
      end
    end
  end

  task automatic run_frame(input logic [27:0] base, input int region, input int frame,
                           input int abort_at, input int stall_at, input bit busy_start);
    int words, acc0, dc0;
    bit got, ab_fired, st_fired;
    logic [255:0] cap_data;
    logic cap_last;
    cfg_base = base; cfg_region_words = 20'(region); cfg_frame_words = 20'(frame);
    model_frame(base, region, frame, (abort_at >= 0) ? 1 : 1 << 30, words);
    dc0 = done_cnt; acc0 = acc_total;
    got = 0; ab_fired = 0; st_fired = 0;
    @(posedge rd_clk); #1 start = 1'b1;
    @(posedge rd_clk); #1 start = 1'b0;
    @(negedge rd_clk);
    chk("start_busy", busy, 1'b1);
    chk("start_aborted_clr", aborted, 1'b0);
    for (int c = 0; c < 20000 && !got; c++) begin
      @(posedge rd_clk); #1;
      start = busy_start && (c == 8);
      if (start) begin cfg_frame_words = 20'd7; cfg_base = 28'h0; cfg_region_words = 20'd3; end
      abort = (abort_at >= 0) && !ab_fired && (acc_total - acc0 >= abort_at);
      if (abort) ab_fired = 1;
      @(negedge rd_clk);
      if (stall_left > 0) begin
        if (stall_left == 5) begin cap_data = wd_data; cap_last = wd_last; end
        else begin
          chk("stall_data", wd_data, cap_data);
          chk("stall_last", wd_last, cap_last);
        end
        chk("stall_no_pop", fifo_rd_en, 1'b0);
        stall_left--;
      end else if (stall_at >= 0 && !st_fired && (acc_total - acc0 >= stall_at)) begin
        stall_left = 5; st_fired = 1;
      end
      if (done) begin
        got = 1;
        chk("end_words_done", words_done, 20'(words));
        chk("end_wr_ptr", wr_ptr, 20'(m_ptr));
        chk("end_aborted", aborted, abort_at >= 0);
      end
    end
    start = 1'b0; abort = 1'b0;
    if (!got) begin
      n_tot++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end
    @(negedge rd_clk);
    chk("post_busy", busy, 1'b0);
    chk("post_done", done, 1'b0);
    chk("done_once", done_cnt - dc0, 1);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("beat_q_empty", last_q.size(), 0);
  endtask

  initial begin
    int words, acc0;
    bit got;
    rd_rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_base = '0; cfg_region_words = '0; cfg_frame_words = '0;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("rst_cmd_valid", cmd_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_wr_ptr", wr_ptr, 0);       chk("rst_words_done", words_done, 0);
    chk("rst_cmd_addr", cmd_addr, 0);   chk("rst_fifo_rd_en", fifo_rd_en, 0);
    @(posedge rd_clk); #1 rd_rst = 1'b0;

    // Basic frame, with an ignored start and cfg change mid-frame.
    run_frame(28'h100, 1000, 40, -1, -1, 1);
    chk("t1_wr_ptr", wr_ptr, 20'd40);
    chk("t1_words", words_done, 20'd40);

    // Region wrap: pointer forced to 0, then split at region end.
    run_frame(28'h2000, 20, 12, -1, -1, 0);
    run_frame(28'h2000, 20, 16, -1, -1, 0);
    chk("t2_wr_ptr", wr_ptr, 20'd8);

    // FIFO valid toggling.
    vld_mode = 1;
    run_frame(28'h4000, 50, 33, -1, -1, 0);
    vld_mode = 0;

    // DDR data stall mid-burst.
    run_frame(28'h6000, 1000, 16, -1, 5, 0);

    // Abort on beat 3, then a clean frame clears aborted.
    run_frame(28'h100, 1000, 40, 3, -1, 0);
    run_frame(28'h100, 1000, 10, -1, -1, 0);

    // Reset mid-burst.
    cfg_base = 28'h300; cfg_region_words = 20'd1000; cfg_frame_words = 20'd40;
    model_frame(28'h300, 1000, 40, 1 << 30, words);
    acc0 = acc_total; got = 0;
    @(posedge rd_clk); #1 start = 1'b1;
    @(posedge rd_clk); #1 start = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge rd_clk);
      if (acc_total - acc0 >= 5) got = 1;
    end
    if (!got) begin n_tot++; $display("FAIL rst_wait_timeout: got no beats expected 5 beats"); end
    @(posedge rd_clk); #1 rd_rst = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    chk("mrst_fifo_rd_en", fifo_rd_en, 0); chk("mrst_cmd_valid", cmd_valid, 0);
    chk("mrst_cmd_addr", cmd_addr, 0);     chk("mrst_cmd_len", cmd_len, 0);
    chk("mrst_wd_valid", wd_valid, 0);     chk("mrst_wd_last", wd_last, 0);
    chk("mrst_busy", busy, 0);             chk("mrst_done", done, 0);
    chk("mrst_aborted", aborted, 0);       chk("mrst_wr_ptr", wr_ptr, 0);
    chk("mrst_words_done", words_done, 0);
    @(posedge rd_clk); #1 rd_rst = 1'b0;
    m_ptr = 0;

    // Randomized frames with random handshakes and small regions.
    for (int f = 0; f < 10; f++) begin
      vld_mode  = $urandom_range(0, 2);
      rdy_mode  = $urandom_range(0, 1);
      crdy_mode = $urandom_range(0, 1);
      run_frame(28'($urandom) & 28'hFFFFFF8, $urandom_range(1, 60), $urandom_range(1, 100), -1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
